acm_reg_bridge: RTL and testbench

Byte-stream command decoder sitting directly downstream of the USB-to-user clock-crossing stage (consumes the user-side out_* stream). It also feeds the user-to-USB crossing stage (drives the in_* stream). It turns a compact binary framing from the host into single 32-bit register reads and writes on a simple strobe/ack bus, then returns a reply frame. It is a drop-in alternative to the soft CPU for bring-up and register poking over the ACM link.

---
 rtl/acm_reg_bridge.sv | 258 +++++++++++++++++++++++++
 tb/tb_acm_reg_bridge.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acm_reg_bridge.sv
// acm_reg_bridge
//   Turns host command frames arriving over the ACM byte stream into single
//   32-bit register reads/writes on a strobe/ack bus, then returns a reply.
//
//   Frames:  'W'(0x57) addr d0 d1 d2 d3   -> write, reply 0x06
//            'R'(0x52) addr               -> read,  reply d0..d3 (LSB first)
//            any other opcode, or bus ack timeout -> reply 0x15 (NAK)
//
// Ports:
//   clk, rst                  user clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready command byte stream in (valid/ready)
//   tx_data/tx_valid/tx_ready reply byte stream out (valid/ready)
//   bus_addr/bus_wdata        register address / write data (held after use)
//   bus_we/bus_re             write/read strobe, high until bus_ack
//   bus_rdata/bus_ack         read data / one-cycle completion
//   busy                      high whenever not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an opcode byte
// ADDR  | waiting for the address byte (inter-byte timeout armed)
// WDATA | collecting write data bytes d0..d3 (inter-byte timeout armed)
// BUS   | strobe asserted, waiting for bus_ack (ack timeout armed)
// RESP  | presenting reply bytes on tx, no timeout

module acm_reg_bridge #(
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy
);

  localparam logic [7:0]      OP_WRITE = 8'h57;
  localparam logic [7:0]      OP_READ  = 8'h52;
  localparam logic [7:0]      REP_ACK  = 8'h06;
  localparam logic [7:0]      REP_NAK  = 8'h15;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            is_read_q, is_read_d;
  logic [1:0]      idx_q, idx_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     resp_word_q, resp_word_d;
  logic [1:0]      resp_last_q, resp_last_d;
  logic            rx_ready_q, rx_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            bus_we_q, bus_we_d;
  logic            bus_re_q, bus_re_d;
  logic            busy_q, busy_d;

  logic            rx_fire;
  logic            tx_fire;
  logic [1:0]      nxt_idx;

  assign rx_fire = rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & tx_ready;

  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    resp_word_d = resp_word_q;
    resp_last_d = resp_last_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = bus_we_q;
    bus_re_d    = bus_re_q;
    nxt_idx     = idx_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_fire) begin
          if (rx_data == OP_WRITE) begin
            state_d   = S_ADDR;
            is_read_d = 1'b0;
          end else if (rx_data == OP_READ) begin
            state_d   = S_ADDR;
            is_read_d = 1'b1;
          end else begin
            // Unknown opcode: NAK immediately so the host can resync.
            state_d     = S_RESP;
            tx_valid_d  = 1'b1;
            tx_data_d   = REP_NAK;
            resp_word_d = {24'h0, REP_NAK};
            resp_last_d = 2'd0;
            idx_d       = 2'd0;
          end
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          cnt_d      = '0;
          bus_addr_d = rx_data;
          idx_d      = 2'd0;
          if (is_read_q) begin
            state_d  = S_BUS;
            bus_re_d = 1'b1;
          end else begin
            state_d = S_WDATA;
          end
        end else if (cnt_q == TO_LAST) begin
          // Host stalled mid-frame: discard silently.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_WDATA: begin
        if (rx_fire) begin
          cnt_d = '0;
          bus_wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
          if (idx_q == 2'd3) begin
            state_d  = S_BUS;
            bus_we_d = 1'b1;
            idx_d    = 2'd0;
          end else begin
            idx_d = nxt_idx;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_BUS: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack) begin
          bus_we_d   = 1'b0;
          bus_re_d   = 1'b0;
          cnt_d      = '0;
          idx_d      = 2'd0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          if (is_read_q) begin
            resp_word_d = bus_rdata;
            resp_last_d = 2'd3;
            tx_data_d   = bus_rdata[7:0];
          end else begin
            resp_word_d = {24'h0, REP_ACK};
            resp_last_d = 2'd0;
            tx_data_d   = REP_ACK;
          end
        end else if (cnt_q == TO_LAST) begin
          bus_we_d    = 1'b0;
          bus_re_d    = 1'b0;
          cnt_d       = '0;
          idx_d       = 2'd0;
          state_d     = S_RESP;
          tx_valid_d  = 1'b1;
          tx_data_d   = REP_NAK;
          resp_word_d = {24'h0, REP_NAK};
          resp_last_d = 2'd0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_RESP: begin
        if (tx_fire) begin
          if (idx_q == resp_last_q) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            idx_d      = 2'd0;
          end else begin
            idx_d     = nxt_idx;
            tx_data_d = resp_word_q[{nxt_idx, 3'b000} +: 8];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      is_read_q   <= 1'b0;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      resp_word_q <= 32'h0;
      resp_last_q <= 2'd0;
      rx_ready_q  <= 1'b1;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h0;
      bus_addr_q  <= 8'h0;
      bus_wdata_q <= 32'h0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      resp_word_q <= resp_word_d;
      resp_last_q <= resp_last_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_acm_reg_bridge.sv
// tb_acm_reg_bridge
//   Self-checking bench for acm_reg_bridge (TIMEOUT=16). A frame-level model
//   predicts the reply bytes, strobe length and bus address/data for each
//   command frame; a cycle helper drives a configurable bus responder and
//   records tx transfers and strobe activity.

module tb_acm_reg_bridge;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;

  acm_reg_bridge #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // observation state
  logic [7:0]  tx_q[$];
  int          we_cycles, re_cycles;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  int          cyc = 0;
  int          last_rx_cyc, ack_cyc, strobe_start, txv_start;

  // responder configuration
  bit          ack_en     = 1'b1;
  int          ack_delay  = 0;
  logic [31:0] cur_rdata  = 32'h0;
  bit          rand_ready = 1'b0;
  bit          spurious   = 1'b0;
  int          strobe_age = 0;

  task automatic clear_obs();
    tx_q.delete();
    we_cycles = 0; re_cycles = 0;
    last_addr = 8'h0; last_wdata = 32'h0;
    last_rx_cyc = -1; ack_cyc = -1; strobe_start = -1; txv_start = -1;
  endtask

  // One clock: record what transfers at this edge, then update responder.
  task automatic tick();
    bit pre_strobe, pre_txv;
    pre_strobe = (bus_we === 1'b1) || (bus_re === 1'b1);
    pre_txv    = (tx_valid === 1'b1);
    if (rst && tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (rst && rx_valid && rx_ready) last_rx_cyc = cyc;
    if (bus_we === 1'b1) we_cycles++;
    if (bus_re === 1'b1) re_cycles++;
    if (pre_strobe) begin
      last_addr  = bus_addr;
      last_wdata = bus_wdata;
      if (bus_ack) ack_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (((bus_we === 1'b1) || (bus_re === 1'b1)) && !pre_strobe) strobe_start = cyc;
    if ((tx_valid === 1'b1) && !pre_txv) txv_start = cyc;
    if ((bus_we === 1'b1) || (bus_re === 1'b1)) begin
      bus_ack = ack_en && (strobe_age == ack_delay);
      strobe_age++;
    end else begin
      strobe_age = 0;
      bus_ack = spurious && ($urandom_range(0, 3) == 0);
    end
    bus_rdata = bus_ack ? cur_rdata : $urandom();
    if (rand_ready) tx_ready = ($urandom_range(0, 1) != 0);
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int max_gap);
    foreach (b[i]) begin
      int gap;
      int guard;
      bit done;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) tick();
      rx_data  = b[i];
      rx_valid = 1'b1;
      guard = 0;
      done  = 1'b0;
      while (!done) begin
        done = (rx_ready === 1'b1);
        tick();
        guard++;
        if (!done && guard > 200) begin
          tests_run++; tests_failed++;
          $display("FAIL rx_accept: byte %0d (%h) not accepted after %0d cycles, required acceptance", i, b[i], guard);
          break;
        end
      end
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy !== 1'b0) begin
      tick();
      guard++;
      if (guard > 300) begin
        tests_run++; tests_failed++;
        $display("FAIL %s idle_wait: busy=%b after %0d cycles, required 0", name, busy, guard);
        return;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b[$], input int max_gap, input string name);
    clear_obs();
    send_bytes(b, max_gap);
    wait_idle(name);
  endtask

  // Frame-level reference: what a correct bridge must do for one frame.
  function automatic void model(input logic [7:0] b[$], input logic [31:0] rd,
                                input bit acked, input int dly,
                                output logic [7:0] rep[$], output int exp_we,
                                output int exp_re, output logic [7:0] ea,
                                output logic [31:0] ew);
    rep.delete();
    exp_we = 0; exp_re = 0; ea = 8'h0; ew = 32'h0;
    if (b[0] == 8'h57) begin
      ea     = b[1];
      ew     = {b[5], b[4], b[3], b[2]};
      exp_we = acked ? dly + 1 : TIMEOUT;
      rep.push_back(acked ? 8'h06 : 8'h15);
    end else if (b[0] == 8'h52) begin
      ea     = b[1];
      exp_re = acked ? dly + 1 : TIMEOUT;
      if (acked) for (int k = 0; k < 4; k++) rep.push_back(rd[8*k +: 8]);
      else rep.push_back(8'h15);
    end else begin
      rep.push_back(8'h15);
    end
  endfunction

  // tx must hold valid and data while back-pressured.
  always @(posedge clk) begin
    logic [7:0] held;
    if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b0) begin
      held = tx_data;
      #1;
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== held) begin
        tests_failed++;
        $display("FAIL tx_hold: got valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, held);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    tests_run++; if (rx_ready !== 1'b1)  begin tests_failed++; $display("FAIL reset_rx_ready: got %b, required 1", rx_ready); end
    tests_run++; if (tx_valid !== 1'b0)  begin tests_failed++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    tests_run++; if (tx_data !== 8'h0)   begin tests_failed++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    tests_run++; if (bus_we !== 1'b0)    begin tests_failed++; $display("FAIL reset_bus_we: got %b, required 0", bus_we); end
    tests_run++; if (bus_re !== 1'b0)    begin tests_failed++; $display("FAIL reset_bus_re: got %b, required 0", bus_re); end
    tests_run++; if (bus_addr !== 8'h0)  begin tests_failed++; $display("FAIL reset_bus_addr: got %h, required 00", bus_addr); end
    tests_run++; if (bus_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_bus_wdata: got %h, required 0", bus_wdata); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [7:0] frame[$], exp[$];
    int ew_c, er_c;
    logic [7:0] ea;
    logic [31:0] ew;
    frame = {8'h57, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ack_en = 1'b1; ack_delay = 2; rand_ready = 1'b0; tx_ready = 1'b1;
    cur_rdata = $urandom();
    model(frame, cur_rdata, 1'b1, 2, exp, ew_c, er_c, ea, ew);
    run_frame(frame, 0, "write");
    tests_run++; if (we_cycles != ew_c) begin tests_failed++; $display("FAIL write_we_cycles: got %0d, required %0d", we_cycles, ew_c); end
    tests_run++; if (re_cycles != er_c) begin tests_failed++; $display("FAIL write_re_cycles: got %0d, required %0d", re_cycles, er_c); end
    tests_run++; if (last_addr !== ea) begin tests_failed++; $display("FAIL write_addr: got %h, required %h", last_addr, ea); end
    tests_run++; if (last_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL write_wdata: got %h, required deadbeef", last_wdata); end
    tests_run++; if (tx_q.size() != 1 || tx_q[0] !== exp[0]) begin tests_failed++; $display("FAIL write_reply: got %0d bytes first %h, required 1 byte %h", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx, exp[0]); end
    tests_run++; if (strobe_start - last_rx_cyc != 1) begin tests_failed++; $display("FAIL write_strobe_latency: got %0d, required 1", strobe_start - last_rx_cyc); end
    tests_run++; if (txv_start - ack_cyc != 1) begin tests_failed++; $display("FAIL write_tx_latency: got %0d, required 1", txv_start - ack_cyc); end
    tests_run++; if (busy !== 1'b0 || bus_addr !== 8'h10 || bus_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL write_after: got busy=%b addr=%h wdata=%h, required 0/10/deadbeef", busy, bus_addr, bus_wdata); end
  endtask

  task automatic test_read();
    logic [7:0] frame[$], exp[$];
    int ew_c, er_c;
    logic [7:0] ea;
    logic [31:0] ew;
    bit bad;
    frame = {8'h52, 8'h22};
    ack_en = 1'b1; ack_delay = 0; rand_ready = 1'b1;
    cur_rdata = 32'h12345678;
    model(frame, cur_rdata, 1'b1, 0, exp, ew_c, er_c, ea, ew);
    run_frame(frame, 0, "read");
    rand_ready = 1'b0; tx_ready = 1'b1;
    tests_run++; if (re_cycles != 1) begin tests_failed++; $display("FAIL read_re_cycles: got %0d, required 1", re_cycles); end
    tests_run++; if (we_cycles != 0) begin tests_failed++; $display("FAIL read_we_cycles: got %0d, required 0", we_cycles); end
    tests_run++; if (last_addr !== 8'h22) begin tests_failed++; $display("FAIL read_addr: got %h, required 22", last_addr); end
    bad = (tx_q.size() != exp.size());
    if (!bad) foreach (exp[i]) if (tx_q[i] !== exp[i]) bad = 1'b1;
    tests_run++; if (bad) begin tests_failed++; $display("FAIL read_reply: got %p, required 78 56 34 12", tx_q); end
    tests_run++; if (strobe_start - last_rx_cyc != 1) begin tests_failed++; $display("FAIL read_strobe_latency: got %0d, required 1", strobe_start - last_rx_cyc); end
    tests_run++; if (txv_start - ack_cyc != 1) begin tests_failed++; $display("FAIL read_tx_latency: got %0d, required 1", txv_start - ack_cyc); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] frame[$], exp[$], rep[$];
    int ew_c, er_c;
    logic [7:0] ea;
    logic [31:0] ew;
    bit bad;
    rand_ready = 1'b0; tx_ready = 1'b0; ack_en = 1'b1; ack_delay = 1;
    clear_obs();
    frame = {8'h41};
    send_bytes(frame, 0);
    tests_run++; if (txv_start - last_rx_cyc != 1) begin tests_failed++; $display("FAIL nak_latency: got %0d, required 1", txv_start - last_rx_cyc); end
    tests_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin tests_failed++; $display("FAIL nak_present: got valid=%b data=%h, required 1/15", tx_valid, tx_data); end
    repeat (3) tick();
    tests_run++; if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL nak_rx_ready: got %b, required 0", rx_ready); end
    tx_ready = 1'b1;
    cur_rdata = $urandom();
    frame = {8'h52, 8'h05};
    model(frame, cur_rdata, 1'b1, 1, rep, ew_c, er_c, ea, ew);
    exp = {8'h15};
    foreach (rep[i]) exp.push_back(rep[i]);
    send_bytes(frame, 0);
    wait_idle("bad_opcode");
    bad = (tx_q.size() != exp.size());
    if (!bad) foreach (exp[i]) if (tx_q[i] !== exp[i]) bad = 1'b1;
    tests_run++; if (bad) begin tests_failed++; $display("FAIL nak_then_read_reply: got %p, required %p", tx_q, exp); end
    tests_run++; if (last_addr !== 8'h05 || re_cycles != er_c) begin tests_failed++; $display("FAIL nak_then_read_bus: got addr=%h re=%0d, required 05/%0d", last_addr, re_cycles, er_c); end
  endtask

  task automatic test_interbyte_timeout();
    logic [7:0] frame[$], exp[$];
    int ew_c, er_c;
    logic [7:0] ea;
    logic [31:0] ew;
    bit bad;
    rand_ready = 1'b0; tx_ready = 1'b1; ack_en = 1'b1; ack_delay = 0;
    clear_obs();
    frame = {8'h57, 8'h10, 8'hAA};
    send_bytes(frame, 0);
    repeat (TIMEOUT - 1) tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ibto_early: got busy=%b one cycle before timeout, required 1", busy); end
    tick();
    tests_run++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin tests_failed++; $display("FAIL ibto_idle: got busy=%b rx_ready=%b, required 0/1", busy, rx_ready); end
    repeat (3) tick();
    tests_run++; if (tx_q.size() != 0 || we_cycles != 0 || re_cycles != 0) begin tests_failed++; $display("FAIL ibto_silent: got tx=%0d we=%0d re=%0d, required 0/0/0", tx_q.size(), we_cycles, re_cycles); end
    cur_rdata = $urandom();
    frame = {8'h52, 8'h10};
    model(frame, cur_rdata, 1'b1, 0, exp, ew_c, er_c, ea, ew);
    run_frame(frame, 0, "ibto_read");
    bad = (tx_q.size() != exp.size());
    if (!bad) foreach (exp[i]) if (tx_q[i] !== exp[i]) bad = 1'b1;
    tests_run++; if (bad || we_cycles != 0 || last_addr !== 8'h10) begin tests_failed++; $display("FAIL ibto_followup: got %p we=%0d addr=%h, required %p 0 10", tx_q, we_cycles, last_addr, exp); end
  endtask

  task automatic test_bus_timeout();
    logic [7:0] frame[$], exp[$];
    int ew_c, er_c;
    logic [7:0] ea;
    logic [31:0] ew;
    rand_ready = 1'b0; tx_ready = 1'b1; ack_en = 1'b0;
    frame = {8'h52, 8'($urandom_range(0, 255))};
    model(frame, cur_rdata, 1'b0, 0, exp, ew_c, er_c, ea, ew);
    run_frame(frame, 0, "bus_timeout");
    ack_en = 1'b1;
    tests_run++; if (re_cycles != er_c) begin tests_failed++; $display("FAIL busto_re_cycles: got %0d, required %0d", re_cycles, er_c); end
    tests_run++; if (tx_q.size() != 1 || tx_q[0] !== exp[0]) begin tests_failed++; $display("FAIL busto_reply: got %p, required %p", tx_q, exp); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] frame[$];
    int guard;
    rand_ready = 1'b0; tx_ready = 1'b1; ack_en = 1'b0;
    clear_obs();
    frame = {8'h57, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04};
    send_bytes(frame, 0);
    repeat (2) tick();
    tests_run++; if (bus_we !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre_we: got %b, required 1", bus_we); end
    rst = 1'b0; tick(); rst = 1'b1;
    tests_run++; if (bus_we !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bus: got we=%b txv=%b rxr=%b busy=%b, required 0/0/1/0", bus_we, tx_valid, rx_ready, busy); end
    repeat (TIMEOUT + 4) tick();
    tests_run++; if (tx_q.size() != 0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bus_stale: got tx=%0d busy=%b, required 0/0", tx_q.size(), busy); end

    ack_en = 1'b1; ack_delay = 1; tx_ready = 1'b0;
    clear_obs();
    frame = {8'h52, 8'h44};
    send_bytes(frame, 0);
    guard = 0;
    while (tx_valid !== 1'b1 && guard < 40) begin tick(); guard++; end
    tests_run++; if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_resp_reach: got tx_valid=%b, required 1", tx_valid); end
    tick();
    rst = 1'b0; tick(); rst = 1'b1;
    tests_run++; if (tx_valid !== 1'b0 || tx_data !== 8'h0 || rx_ready !== 1'b1 || busy !== 1'b0 || bus_re !== 1'b0) begin tests_failed++; $display("FAIL rstmid_resp: got txv=%b txd=%h rxr=%b busy=%b re=%b, required 0/00/1/0/0", tx_valid, tx_data, rx_ready, busy, bus_re); end
    tx_ready = 1'b1;
    repeat (8) tick();
    tests_run++; if (tx_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_resp_stale: got %0d tx bytes, required 0", tx_q.size()); end
  endtask

  task automatic test_random();
    logic [7:0] frame[$], exp[$];
    int ew_c, er_c, kind;
    logic [7:0] ea, op;
    logic [31:0] ew;
    bit acked, bad;
    rand_ready = 1'b1; spurious = 1'b1;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      frame.delete();
      if (kind <= 4) begin
        frame.push_back(8'h57);
        for (int k = 0; k < 5; k++) frame.push_back(8'($urandom_range(0, 255)));
      end else if (kind <= 8) begin
        frame = {8'h52, 8'($urandom_range(0, 255))};
      end else begin
        op = 8'($urandom_range(0, 255));
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
        frame.push_back(op);
      end
      acked     = ($urandom_range(0, 7) != 0);
      ack_en    = acked;
      ack_delay = $urandom_range(0, 4);
      cur_rdata = $urandom();
      model(frame, cur_rdata, acked, ack_delay, exp, ew_c, er_c, ea, ew);
      run_frame(frame, 3, "random");
      bad = (tx_q.size() != exp.size());
      if (!bad) foreach (exp[i]) if (tx_q[i] !== exp[i]) bad = 1'b1;
      tests_run++; if (bad) begin tests_failed++; $display("FAIL rand_reply[%0d]: got %p, required %p", n, tx_q, exp); end
      tests_run++; if (we_cycles != ew_c || re_cycles != er_c) begin tests_failed++; $display("FAIL rand_strobe[%0d]: got we=%0d re=%0d, required %0d/%0d", n, we_cycles, re_cycles, ew_c, er_c); end
      if (ew_c != 0 || er_c != 0) begin
        tests_run++;
        if (last_addr !== ea || (ew_c != 0 && last_wdata !== ew)) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: got addr=%h wdata=%h, required %h/%h", n, last_addr, last_wdata, ea, ew);
        end
      end
    end
    rand_ready = 1'b0; spurious = 1'b0; tx_ready = 1'b1; ack_en = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rx_data = 8'h0; rx_valid = 1'b0; tx_ready = 1'b1;
    bus_rdata = 32'h0; bus_ack = 1'b0;
    clear_obs();
    test_reset();
    test_write();
    test_read();
    test_bad_opcode();
    test_interbyte_timeout();
    test_bus_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
